// File: rtl/instr_fetch_pkg.sv
// ---------------------------------------------------------------------------
// instr_fetch_pkg
// Shared definitions for the instruction-fetch stage: machine word width,
// default bubble instruction, fetch FSM state encodings and a small address
// helper.
// ---------------------------------------------------------------------------
package instr_fetch_pkg;

  localparam int unsigned WORD_W = 32;

  // Bubble placed in the instruction register on reset, flush and drop.
  localparam logic [WORD_W-1:0] IR_NOP_DEFAULT = 32'h0000_0000;

  typedef enum logic [2:0] {
    st_idle  = 3'd0,
    st_req   = 3'd1,
    st_full  = 3'd2,
    st_drain = 3'd3,
    st_err   = 3'd4
  } fetch_state_e;

  // Instructions are word aligned; any low address bit set is a fetch error.
  function automatic logic word_aligned(input logic [WORD_W-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_if
// Instruction-memory read channel between the fetch stage and memory.
//   imem_req   : read request, held until imem_ack
//   imem_addr  : read address, stable while imem_req is high
//   imem_ack   : one-cycle acknowledge, imem_rdata valid in the same cycle
//   imem_rdata : instruction word returned by memory
// Modports: master = fetch stage, slave = memory.
// ---------------------------------------------------------------------------
interface instr_fetch_if;
  import instr_fetch_pkg::*;

  logic              imem_req;
  logic [WORD_W-1:0] imem_addr;
  logic              imem_ack;
  logic [WORD_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Single-entry instruction fetch stage. Reads the word at pc from
// instruction memory, holds it in the instruction register until decode
// consumes it, and pulses PCWre so the PC register advances or redirects.
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   reset     : asynchronous active-low reset
//   pc        : current program counter
//   PCWre     : one-cycle PC write enable (consume or flush)
//   imem      : instruction-memory read channel (master side)
//   flush     : downstream redirect, discards current / in-flight fetch
//   id_ready  : decode accepts ir this cycle
//   ir_valid  : ir / ir_pc / ir_pc4 hold a valid instruction
//   ir        : fetched instruction word
//   ir_pc     : address of ir
//   ir_pc4    : ir_pc + 4 (wraps modulo 2^32)
//   fetch_err : misaligned pc seen; cleared only by flush
// ---------------------------------------------------------------------------
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] IR_NOP = IR_NOP_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] pc,
  output logic              PCWre,
  instr_fetch_if.master     imem,
  input  logic              flush,
  input  logic              id_ready,
  output logic              ir_valid,
  output logic [WORD_W-1:0] ir,
  output logic [WORD_W-1:0] ir_pc,
  output logic [WORD_W-1:0] ir_pc4,
  output logic              fetch_err
);

  fetch_state_e      state_r;
  fetch_state_e      state_nxt_s;
  logic              latch_addr_s;
  logic              capture_s;
  logic              drop_s;
  logic              consume_s;

  logic              imem_req_r;
  logic [WORD_W-1:0] imem_addr_r;
  logic              ir_valid_r;
  logic              fetch_err_r;
  logic [WORD_W-1:0] ir_r;
  logic [WORD_W-1:0] ir_pc_r;
  logic [WORD_W-1:0] ir_pc4_r;

  // Next-state and per-cycle control decode for the fetch FSM.
  always_comb begin
    state_nxt_s  = state_r;
    latch_addr_s = 1'b0;
    capture_s    = 1'b0;
    drop_s       = flush;   // any flush turns ir into a bubble
    consume_s    = 1'b0;
    case (state_r)
      st_idle: begin
        if (!word_aligned(pc)) begin
          state_nxt_s = st_err;
        end else begin
          latch_addr_s = 1'b1;
          state_nxt_s  = st_req;
        end
      end
      st_req: begin
        if (flush) begin
          // Ack in the flush cycle: data is simply dropped. Otherwise the
          // request is still outstanding and must be drained.
          if (imem.imem_ack) begin
            state_nxt_s = st_idle;
          end else begin
            state_nxt_s = st_drain;
          end
        end else if (imem.imem_ack) begin
          capture_s   = 1'b1;
          state_nxt_s = st_full;
        end else begin
          state_nxt_s = st_req;
        end
      end
      st_drain: begin
        if (imem.imem_ack) begin
          drop_s      = 1'b1;
          state_nxt_s = st_idle;
        end else begin
          state_nxt_s = st_drain;
        end
      end
      st_full: begin
        // flush has priority over id_ready
        if (flush) begin
          state_nxt_s = st_idle;
        end else if (id_ready) begin
          consume_s   = 1'b1;
          state_nxt_s = st_idle;
        end else begin
          state_nxt_s = st_full;
        end
      end
      st_err: begin
        if (flush) begin
          state_nxt_s = st_idle;
        end else begin
          state_nxt_s = st_err;
        end
      end
      default: begin
        drop_s      = 1'b1;
        state_nxt_s = st_idle;
      end
    endcase
  end

  // State register plus state-decoded status flags, registered from next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= st_idle;
      imem_req_r  <= 1'b0;
      ir_valid_r  <= 1'b0;
      fetch_err_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      imem_req_r  <= (state_nxt_s == st_req) || (state_nxt_s == st_drain);
      ir_valid_r  <= (state_nxt_s == st_full);
      fetch_err_r <= (state_nxt_s == st_err);
    end
  end

  // Read address: only loaded in IDLE so it cannot move under a live request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      imem_addr_r <= 32'h0000_0000;
    end else if (latch_addr_s) begin
      imem_addr_r <= pc;
    end else begin
      imem_addr_r <= imem_addr_r;
    end
  end

  // Instruction register with its address and fall-through address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir_r     <= IR_NOP;
      ir_pc_r  <= 32'h0000_0000;
      ir_pc4_r <= 32'h0000_0000;
    end else if (capture_s) begin
      ir_r     <= imem.imem_rdata;
      ir_pc_r  <= imem_addr_r;
      ir_pc4_r <= imem_addr_r + 32'd4;   // carry out discarded: wraps to 0
    end else if (drop_s) begin
      ir_r     <= IR_NOP;
    end else begin
      ir_r     <= ir_r;
    end
  end

  // PC write is combinational so the PC register updates on the same edge
  // that retires or redirects; held low while reset is asserted.
  assign PCWre = reset & (flush | consume_s);

  assign imem.imem_req  = imem_req_r;
  assign imem.imem_addr = imem_addr_r;
  assign ir_valid       = ir_valid_r;
  assign fetch_err      = fetch_err_r;
  assign ir             = ir_r;
  assign ir_pc          = ir_pc_r;
  assign ir_pc4         = ir_pc4_r;

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
// Directed bench for instr_fetch. Stimulus pushes expected request addresses
// and expected retired instructions into queues; a monitor pops and compares
// when the DUT raises imem_req or retires an instruction. A small memory
// responder and a PC register model surround the DUT.
// ---------------------------------------------------------------------------
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] pc4;
  } inst_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc = 32'h0000_0000;
  logic        PCWre;
  logic        flush;
  logic        id_ready;
  logic        ir_valid;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic [31:0] ir_pc4;
  logic        fetch_err;

  instr_fetch_if bus ();

  instr_fetch #(.IR_NOP(NOP)) dut (
    .clk       (clk),
    .reset     (reset),
    .pc        (pc),
    .PCWre     (PCWre),
    .imem      (bus),
    .flush     (flush),
    .id_ready  (id_ready),
    .ir_valid  (ir_valid),
    .ir        (ir),
    .ir_pc     (ir_pc),
    .ir_pc4    (ir_pc4),
    .fetch_err (fetch_err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass = 0;
  int          consumed_cnt = 0;
  int          pcwre_cnt = 0;
  logic [31:0] exp_req[$];
  inst_t       exp_inst[$];

  int          ack_budget = 0;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  bit          late_ack = 1'b0;
  bit          ovr_en = 1'b0;
  logic [31:0] ovr_data = 32'h0000_0000;
  logic [31:0] redirect_pc = 32'h0000_0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    n_checks++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0200_0001;
      32'h0000_0004: return 32'h0040_0093;
      32'h0000_0008: return 32'h0000_8067;
      32'h0000_0010: return 32'h0010_0513;
      32'h0000_0040: return 32'h1234_5678;
      32'hFFFF_FFFC: return 32'hCAFE_F00D;
      default:       return 32'hBAD0_0000;
    endcase
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ir_valid"},  {31'd0, ir_valid},       32'd0);
    check({tag, "_ir"},        ir,                      NOP);
    check({tag, "_ir_pc"},     ir_pc,                   32'd0);
    check({tag, "_ir_pc4"},    ir_pc4,                  32'd0);
    check({tag, "_imem_addr"}, bus.imem_addr,           32'd0);
    check({tag, "_imem_req"},  {31'd0, bus.imem_req},   32'd0);
    check({tag, "_fetch_err"}, {31'd0, fetch_err},      32'd0);
    check({tag, "_pcwre"},     {31'd0, PCWre},          32'd0);
  endtask

  // which: 0 = ir_valid, 1 = imem_req
  task automatic wait_for(input int which, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(posedge clk); #1;
      if (which == 0) hit = (ir_valid === 1'b1);
      else            hit = (bus.imem_req === 1'b1);
    end
    if (!hit) timeout(name);
  endtask

  task automatic wait_consumed(input int target, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(posedge clk); #1;
      hit = (consumed_cnt >= target);
    end
    if (!hit) timeout(name);
  endtask

  // Memory responder: acks after ack_delay request cycles while budget lasts.
  initial begin
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0000_0000;
    forever begin
      @(posedge clk); #2;
      bus.imem_ack = 1'b0;
      if (late_ack) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        late_ack       = 1'b0;
      end else if (ack_budget > 0 && bus.imem_req === 1'b1) begin
        if (wait_cnt >= ack_delay) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = ovr_en ? ovr_data : mem_word(bus.imem_addr);
          ack_budget--;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // PC register model: advance by 4 on retire, load redirect on flush.
  initial begin
    bit upd;
    bit fl;
    forever begin
      @(negedge clk);
      upd = (PCWre === 1'b1);
      fl  = flush;
      @(posedge clk); #1;
      if (upd) pc = fl ? redirect_pc : pc + 32'd4;
    end
  end

  // Monitor: request addresses and retired instructions against the queues.
  initial begin
    bit          prev_req = 1'b0;
    logic [31:0] held_addr = 32'h0000_0000;
    logic [31:0] ea;
    inst_t       e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        if (bus.imem_req === 1'b1 && !prev_req) begin
          if (exp_req.size() == 0) begin
            check("unexpected_req", bus.imem_addr, 32'hFFFF_FFFF);
          end else begin
            ea = exp_req.pop_front();
            check("req_addr", bus.imem_addr, ea);
            held_addr = ea;
          end
        end else if (bus.imem_req === 1'b1) begin
          check("addr_stable", bus.imem_addr, held_addr);
        end
        if (ir_valid === 1'b1 && id_ready && !flush) begin
          if (exp_inst.size() == 0) begin
            check("unexpected_retire", ir, 32'hFFFF_FFFF);
          end else begin
            e = exp_inst.pop_front();
            check("retire_ir",     ir,               e.ir);
            check("retire_ir_pc",  ir_pc,            e.pc);
            check("retire_ir_pc4", ir_pc4,           e.pc4);
            check("retire_pcwre",  {31'd0, PCWre},   32'd1);
          end
          consumed_cnt++;
        end
        if (PCWre === 1'b1) pcwre_cnt++;
        prev_req = (bus.imem_req === 1'b1);
      end else begin
        prev_req = 1'b0;
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Directed stimulus.
  initial begin
    reset    = 1'b0;
    flush    = 1'b0;
    id_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");

    // Basic fetch at 0 with ack one cycle after request.
    exp_req.push_back(32'h0000_0000);
    exp_req.push_back(32'h0000_0004);
    exp_inst.push_back({32'h0200_0001, 32'h0000_0000, 32'h0000_0004});
    ack_delay  = 1;
    ack_budget = 1;
    id_ready   = 1'b1;
    reset      = 1'b1;
    wait_consumed(1, "t1_retire");
    check("t1_pcwre_cnt", pcwre_cnt, 32'd1);

    // Decode stalls for 5 cycles in FULL.
    id_ready = 1'b0;
    exp_inst.push_back({32'h0040_0093, 32'h0000_0004, 32'h0000_0008});
    exp_req.push_back(32'h0000_0008);
    ack_delay  = 0;
    ack_budget = 1;
    wait_for(1, "t2_req");
    @(negedge clk);
    check("t2_valid_before_ack_edge", {31'd0, ir_valid}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_hold_valid", {31'd0, ir_valid}, 32'd1);
      check("t2_hold_ir",    ir,                32'h0040_0093);
      check("t2_hold_ir_pc", ir_pc,             32'h0000_0004);
      check("t2_hold_pcwre", {31'd0, PCWre},    32'd0);
    end
    @(posedge clk); #1;
    id_ready = 1'b1;
    wait_consumed(2, "t2_retire");
    check("t2_pcwre_cnt", pcwre_cnt, 32'd2);

    // flush together with id_ready in FULL.
    id_ready = 1'b0;
    ack_budget = 1;
    wait_for(0, "t3_valid");
    flush       = 1'b1;
    id_ready    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    exp_req.push_back(32'hFFFF_FFFC);
    @(negedge clk);
    check("t3_pcwre", {31'd0, PCWre}, 32'd1);
    @(posedge clk); #1;
    flush    = 1'b0;
    id_ready = 1'b0;
    check("t3_valid_cleared", {31'd0, ir_valid}, 32'd0);
    check("t3_ir_nop",        ir,                NOP);
    @(posedge clk); #1;
    check("t3_pcwre_cnt", pcwre_cnt, 32'd3);

    // Fetch at the top of the address space: ir_pc4 wraps.
    exp_inst.push_back({32'hCAFE_F00D, 32'hFFFF_FFFC, 32'h0000_0000});
    exp_req.push_back(32'h0000_0000);
    ack_budget = 1;
    id_ready   = 1'b1;
    wait_consumed(3, "t4_retire");
    id_ready = 1'b0;

    // flush in REQ, late ack of DEADBEEF while pc moves to 0x40.
    wait_for(1, "t5_req");
    flush       = 1'b1;
    redirect_pc = 32'h0000_0040;
    exp_req.push_back(32'h0000_0040);
    @(posedge clk); #1;
    flush      = 1'b0;
    ovr_en     = 1'b1;
    ovr_data   = 32'hDEAD_BEEF;
    ack_delay  = 2;
    ack_budget = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_drain_req",   {31'd0, bus.imem_req}, 32'd1);
      check("t5_drain_addr",  bus.imem_addr,         32'h0000_0000);
      check("t5_drain_valid", {31'd0, ir_valid},     32'd0);
    end
    @(negedge clk);
    check("t5_idle_req",   {31'd0, bus.imem_req}, 32'd0);
    check("t5_idle_valid", {31'd0, ir_valid},     32'd0);
    check("t5_idle_ir",    ir,                    NOP);
    @(negedge clk);
    check("t5_new_addr",  bus.imem_addr,     32'h0000_0040);
    check("t5_new_valid", {31'd0, ir_valid}, 32'd0);
    ovr_en = 1'b0;

    // Misaligned redirect to 6 -> ERR; flush to 8 recovers.
    @(posedge clk); #1;
    flush       = 1'b1;
    redirect_pc = 32'h0000_0006;
    @(posedge clk); #1;
    flush      = 1'b0;
    ack_delay  = 0;
    ack_budget = 1;
    @(posedge clk);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_err_flag", {31'd0, fetch_err},    32'd1);
      check("t6_err_req",  {31'd0, bus.imem_req}, 32'd0);
    end
    @(posedge clk); #1;
    flush       = 1'b1;
    redirect_pc = 32'h0000_0008;
    exp_req.push_back(32'h0000_0008);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("t6_err_cleared", {31'd0, fetch_err},    32'd0);
    check("t6_idle_req",    {31'd0, bus.imem_req}, 32'd0);
    @(negedge clk);
    check("t6_req_on",   {31'd0, bus.imem_req}, 32'd1);
    check("t6_req_addr", bus.imem_addr,         32'h0000_0008);

    // Reset in the middle of DRAIN, then a stale ack after release.
    @(posedge clk); #1;
    flush       = 1'b1;
    redirect_pc = 32'h0000_0010;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("t7_in_drain", {31'd0, bus.imem_req}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("t7_async_rst");
    late_ack = 1'b1;
    exp_req.push_back(32'h0000_0010);
    @(negedge clk); #2;
    reset = 1'b1;
    @(negedge clk);
    check("t7_late_ack_valid", {31'd0, ir_valid}, 32'd0);
    @(negedge clk);
    check("t7_late_ack_valid2", {31'd0, ir_valid}, 32'd0);
    check("t7_late_ack_ir",     ir,                NOP);

    // Normal fetch after recovery.
    @(posedge clk); #1;
    exp_inst.push_back({32'h0010_0513, 32'h0000_0010, 32'h0000_0014});
    exp_req.push_back(32'h0000_0014);
    ack_budget = 1;
    id_ready   = 1'b1;
    wait_consumed(4, "t8_retire");
    id_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("end_req_queue",  exp_req.size(),  32'd0);
    check("end_inst_queue", exp_inst.size(), 32'd0);
    check("end_pcwre_cnt",  pcwre_cnt,       32'd9);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
